// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU address-generation stage.
//   - LSU op_type encodings (bit3 = store, bit2 = unsigned, bits[1:0] = size)
//   - access-size field values
//   - fence-ordering FSM state type
//   - small helpers to decode op_type fields
package lsu_pkg;

  localparam logic [3:0] LSU_LB  = 4'd0;
  localparam logic [3:0] LSU_LH  = 4'd1;
  localparam logic [3:0] LSU_LW  = 4'd2;
  localparam logic [3:0] LSU_LBU = 4'd4;
  localparam logic [3:0] LSU_LHU = 4'd5;
  localparam logic [3:0] LSU_SB  = 4'd8;
  localparam logic [3:0] LSU_SH  = 4'd9;
  localparam logic [3:0] LSU_SW  = 4'd10;

  localparam logic [1:0] SIZE_B    = 2'd0;
  localparam logic [1:0] SIZE_H    = 2'd1;
  localparam logic [1:0] SIZE_W    = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef enum logic {
    FSM_IDLE  = 1'b0,
    FSM_DRAIN = 1'b1
  } lsu_fsm_e;

  function automatic logic [1:0] op_size(input logic [3:0] op);
    return op[1:0];
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/vx_lsu_lane_fmt.sv
// Per-thread request formatting (purely combinational).
//   base_addr, offset -> addr       : effective byte address (mod 2^32)
//   size, addr[1:0]   -> byteen     : byte enables within the 32-bit word
//   store_data        -> data       : store data shifted into its byte lane
//   active            -> misaligned : misalignment flag, zero for idle threads
module vx_lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] base_addr,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  input  logic [1:0]  size,
  input  logic        active,
  output logic [31:0] addr,
  output logic [3:0]  byteen,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [1:0] lo;
  logic       raw_mis;

  assign addr = base_addr + offset;
  assign lo   = addr[1:0];
  assign data = store_data << {lo, 3'b000};
  assign misaligned = raw_mis & active;

  always_comb begin
    byteen  = 4'b0000;
    raw_mis = 1'b0;
    case (size)
      SIZE_B: byteen = 4'b0001 << lo;
      SIZE_H: begin
        byteen  = 4'b0011 << lo;
        raw_mis = lo[0];
      end
      SIZE_W: begin
        byteen  = 4'hF;
        raw_mis = (lo != 2'b00);
      end
      // Reserved size: no bytes touched, always flagged so downstream traps.
      default: raw_mis = 1'b1;
    endcase
  end

endmodule

// File: rtl/vx_lsu_addr_gen.sv
// LSU address generation stage.
// Accepts one warp-wide LSU request per in_valid/in_ready handshake, formats
// per-thread addresses/byte enables/store data, and presents one registered
// memory request (out_*) toward the data-cache adapter with valid/ready.
// Fences are absorbed here: a fence waits until the output register is empty
// and every issued request has been retired (mem_rsp_done), then fence_done
// pulses for one cycle with fence_wid.
// Ports: clk/reset, in_* request side, out_* memory request side,
//        mem_rsp_done retire pulse, fence_done/fence_wid, pending_cnt.
module vx_lsu_addr_gen
  import lsu_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 5,
  parameter int MAX_PENDING = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [NW_BITS-1:0]            in_wid,
  input  logic [NUM_THREADS-1:0]        in_tmask,
  input  logic [31:0]                   in_PC,
  input  logic [3:0]                    in_op_type,
  input  logic                          in_is_fence,
  input  logic [NUM_THREADS*32-1:0]     in_store_data,
  input  logic [NUM_THREADS*32-1:0]     in_base_addr,
  input  logic [31:0]                   in_offset,
  input  logic [NR_BITS-1:0]            in_rd,
  input  logic                          in_wb,
  input  logic                          in_is_prefetch,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic                          out_rw,
  output logic [NW_BITS-1:0]            out_wid,
  output logic [NUM_THREADS-1:0]        out_tmask,
  output logic [31:0]                   out_PC,
  output logic [NR_BITS-1:0]            out_rd,
  output logic                          out_wb,
  output logic                          out_is_prefetch,
  output logic [3:0]                    out_op_type,
  output logic [NUM_THREADS*32-1:0]     out_addr,
  output logic [NUM_THREADS*4-1:0]      out_byteen,
  output logic [NUM_THREADS*32-1:0]     out_data,
  output logic [NUM_THREADS-1:0]        out_misaligned,
  input  logic                          out_ready,
  input  logic                          mem_rsp_done,
  output logic                          fence_done,
  output logic [NW_BITS-1:0]            fence_wid,
  output logic [$clog2(MAX_PENDING):0]  pending_cnt
);

  localparam int PCNT_W = $clog2(MAX_PENDING) + 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(MAX_PENDING);
  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);

  // Per-thread formatting
  logic [NUM_THREADS*32-1:0] fmt_addr;
  logic [NUM_THREADS*32-1:0] fmt_data;
  logic [NUM_THREADS*4-1:0]  fmt_byteen;
  logic [NUM_THREADS-1:0]    fmt_mis;

  generate
    for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_lane
      vx_lsu_lane_fmt u_lane (
        .base_addr  (in_base_addr[gi*32 +: 32]),
        .offset     (in_offset),
        .store_data (in_store_data[gi*32 +: 32]),
        .size       (op_size(in_op_type)),
        .active     (in_tmask[gi]),
        .addr       (fmt_addr[gi*32 +: 32]),
        .byteen     (fmt_byteen[gi*4 +: 4]),
        .data       (fmt_data[gi*32 +: 32]),
        .misaligned (fmt_mis[gi])
      );
    end
  endgenerate

  // State
  lsu_fsm_e                  state_q, state_d;
  logic [NW_BITS-1:0]        fence_wid_q, fence_wid_d;
  logic [PCNT_W-1:0]         pending_q, pending_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_rw_q, out_rw_d;
  logic [NW_BITS-1:0]        out_wid_q, out_wid_d;
  logic [NUM_THREADS-1:0]    out_tmask_q, out_tmask_d;
  logic [31:0]               out_pc_q, out_pc_d;
  logic [NR_BITS-1:0]        out_rd_q, out_rd_d;
  logic                      out_wb_q, out_wb_d;
  logic                      out_pf_q, out_pf_d;
  logic [3:0]                out_op_q, out_op_d;
  logic [NUM_THREADS*32-1:0] out_addr_q, out_addr_d;
  logic [NUM_THREADS*4-1:0]  out_byteen_q, out_byteen_d;
  logic [NUM_THREADS*32-1:0] out_data_q, out_data_d;
  logic [NUM_THREADS-1:0]    out_mis_q, out_mis_d;

  // Handshake decode. A retire in the same cycle frees a slot, so a full
  // counter only blocks when no response is arriving.
  logic pend_full, in_ready_w, in_fire, req_fire, fence_fire;
  logic out_fire, rsp_fire, drain_done;

  assign pend_full  = (pending_q == PCNT_MAX) & ~mem_rsp_done;
  assign in_ready_w = (state_q == FSM_IDLE) & (~out_valid_q | out_ready) & ~pend_full;
  assign in_fire    = in_valid & in_ready_w;
  assign req_fire   = in_fire & ~in_is_fence;
  assign fence_fire = in_fire & in_is_fence;
  assign out_fire   = out_valid_q & out_ready;
  // A retire with nothing outstanding is dropped so the counter cannot wrap.
  assign rsp_fire   = mem_rsp_done & (pending_q != '0);
  assign drain_done = (state_q == FSM_DRAIN) & ~out_valid_q & (pending_q == '0);

  always_comb begin
    state_d     = state_q;
    fence_wid_d = fence_wid_q;
    case (state_q)
      FSM_IDLE: begin
        if (fence_fire) begin
          state_d     = FSM_DRAIN;
          fence_wid_d = in_wid;
        end
      end
      FSM_DRAIN: begin
        if (drain_done) state_d = FSM_IDLE;
      end
      default: state_d = FSM_IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    case ({out_fire, rsp_fire})
      2'b10:   pending_d = pending_q + PCNT_ONE;
      2'b01:   pending_d = pending_q - PCNT_ONE;
      default: pending_d = pending_q;
    endcase
  end

  // Output register: load on a new request (even while the current one is
  // leaving, for full throughput), otherwise hold every field.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_rw_d     = out_rw_q;
    out_wid_d    = out_wid_q;
    out_tmask_d  = out_tmask_q;
    out_pc_d     = out_pc_q;
    out_rd_d     = out_rd_q;
    out_wb_d     = out_wb_q;
    out_pf_d     = out_pf_q;
    out_op_d     = out_op_q;
    out_addr_d   = out_addr_q;
    out_byteen_d = out_byteen_q;
    out_data_d   = out_data_q;
    out_mis_d    = out_mis_q;
    if (req_fire) begin
      out_valid_d  = 1'b1;
      out_rw_d     = op_is_store(in_op_type);
      out_wid_d    = in_wid;
      out_tmask_d  = in_tmask;
      out_pc_d     = in_PC;
      out_rd_d     = in_rd;
      out_wb_d     = in_wb;
      out_pf_d     = in_is_prefetch;
      out_op_d     = in_op_type;
      out_addr_d   = fmt_addr;
      out_byteen_d = fmt_byteen;
      out_data_d   = fmt_data;
      out_mis_d    = fmt_mis;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FSM_IDLE;
      fence_wid_q  <= '0;
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_rw_q     <= 1'b0;
      out_wid_q    <= '0;
      out_tmask_q  <= '0;
      out_pc_q     <= '0;
      out_rd_q     <= '0;
      out_wb_q     <= 1'b0;
      out_pf_q     <= 1'b0;
      out_op_q     <= '0;
      out_addr_q   <= '0;
      out_byteen_q <= '0;
      out_data_q   <= '0;
      out_mis_q    <= '0;
    end else begin
      state_q      <= state_d;
      fence_wid_q  <= fence_wid_d;
      pending_q    <= pending_d;
      out_valid_q  <= out_valid_d;
      out_rw_q     <= out_rw_d;
      out_wid_q    <= out_wid_d;
      out_tmask_q  <= out_tmask_d;
      out_pc_q     <= out_pc_d;
      out_rd_q     <= out_rd_d;
      out_wb_q     <= out_wb_d;
      out_pf_q     <= out_pf_d;
      out_op_q     <= out_op_d;
      out_addr_q   <= out_addr_d;
      out_byteen_q <= out_byteen_d;
      out_data_q   <= out_data_d;
      out_mis_q    <= out_mis_d;
    end
  end

  assign in_ready        = in_ready_w;
  assign out_valid       = out_valid_q;
  assign out_rw          = out_rw_q;
  assign out_wid         = out_wid_q;
  assign out_tmask       = out_tmask_q;
  assign out_PC          = out_pc_q;
  assign out_rd          = out_rd_q;
  assign out_wb          = out_wb_q;
  assign out_is_prefetch = out_pf_q;
  assign out_op_type     = out_op_q;
  assign out_addr        = out_addr_q;
  assign out_byteen      = out_byteen_q;
  assign out_data        = out_data_q;
  assign out_misaligned  = out_mis_q;
  // Completion is visible during the single DRAIN cycle in which everything
  // is empty; suppressed while reset is asserted.
  assign fence_done      = drain_done & ~reset;
  assign fence_wid       = fence_wid_q;
  assign pending_cnt     = pending_q;

endmodule

// File: tb/tb_vx_lsu_addr_gen.sv
module tb_vx_lsu_addr_gen;
  import lsu_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [1:0]   in_wid;
  logic [3:0]   in_tmask;
  logic [31:0]  in_PC;
  logic [3:0]   in_op_type;
  logic         in_is_fence;
  logic [127:0] in_store_data;
  logic [127:0] in_base_addr;
  logic [31:0]  in_offset;
  logic [4:0]   in_rd;
  logic         in_wb;
  logic         in_is_prefetch;
  logic         in_ready;
  logic         out_valid;
  logic         out_rw;
  logic [1:0]   out_wid;
  logic [3:0]   out_tmask;
  logic [31:0]  out_PC;
  logic [4:0]   out_rd;
  logic         out_wb;
  logic         out_is_prefetch;
  logic [3:0]   out_op_type;
  logic [127:0] out_addr;
  logic [15:0]  out_byteen;
  logic [127:0] out_data;
  logic [3:0]   out_misaligned;
  logic         out_ready;
  logic         mem_rsp_done;
  logic         fence_done;
  logic [1:0]   fence_wid;
  logic [4:0]   pending_cnt;

  int n_cmp = 0;
  int n_err = 0;

  vx_lsu_addr_gen #(
    .NUM_THREADS(4), .NW_BITS(2), .NR_BITS(5), .MAX_PENDING(16)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_wid(in_wid), .in_tmask(in_tmask), .in_PC(in_PC),
    .in_op_type(in_op_type), .in_is_fence(in_is_fence),
    .in_store_data(in_store_data), .in_base_addr(in_base_addr),
    .in_offset(in_offset), .in_rd(in_rd), .in_wb(in_wb),
    .in_is_prefetch(in_is_prefetch), .in_ready(in_ready),
    .out_valid(out_valid), .out_rw(out_rw), .out_wid(out_wid),
    .out_tmask(out_tmask), .out_PC(out_PC), .out_rd(out_rd), .out_wb(out_wb),
    .out_is_prefetch(out_is_prefetch), .out_op_type(out_op_type),
    .out_addr(out_addr), .out_byteen(out_byteen), .out_data(out_data),
    .out_misaligned(out_misaligned), .out_ready(out_ready),
    .mem_rsp_done(mem_rsp_done), .fence_done(fence_done),
    .fence_wid(fence_wid), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] tm,
                       input logic [127:0] base, input logic [31:0] off,
                       input logic [127:0] sd, input logic [1:0] wid,
                       input logic pf);
    in_valid       = 1'b1;
    in_is_fence    = 1'b0;
    in_op_type     = op;
    in_tmask       = tm;
    in_base_addr   = base;
    in_offset      = off;
    in_store_data  = sd;
    in_wid         = wid;
    in_is_prefetch = pf;
    in_PC          = 32'h8000_0000 + {28'd0, op};
    in_rd          = 5'd7;
    in_wb          = ~op[3];
    #1;
    $display("tx op=%0h tmask=%0h base0=%h off=%h wid=%0d pf=%0b", op, tm, base[31:0], off, wid, pf);
  endtask

  task automatic drive_fence(input logic [1:0] wid);
    in_valid    = 1'b1;
    in_is_fence = 1'b1;
    in_wid      = wid;
    #1;
    $display("tx fence wid=%0d", wid);
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_is_fence = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_wid = 0; in_tmask = 0; in_PC = 0;
    in_op_type = 0; in_is_fence = 0; in_store_data = 0; in_base_addr = 0;
    in_offset = 0; in_rd = 0; in_wb = 0; in_is_prefetch = 0;
    out_ready = 1'b1; mem_rsp_done = 1'b0;
    repeat (3) tick();
    reset = 1'b0; #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fence_done", fence_done, 0);
    chk("rst_pending", pending_cnt, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_in_ready", in_ready, 1);

    // LW, 4 threads, offset 4
    drive(LSU_LW, 4'hF, {32'h10C, 32'h108, 32'h104, 32'h100}, 32'd4, 128'd0, 2'd1, 1'b0);
    chk("lw_in_ready", in_ready, 1);
    tick(); idle();
    chk("lw_valid", out_valid, 1);
    chk("lw_addr", out_addr, {32'h110, 32'h10C, 32'h108, 32'h104});
    chk("lw_byteen", out_byteen, 16'hFFFF);
    chk("lw_mis", out_misaligned, 0);
    chk("lw_rw", out_rw, 0);
    chk("lw_wid", out_wid, 1);
    tick();
    chk("lw_pend", pending_cnt, 1);
    chk("lw_valid_clr", out_valid, 0);

    // SB to 0x203
    drive(LSU_SB, 4'h1, {96'd0, 32'h203}, 32'd0, {96'd0, 32'hAB}, 2'd2, 1'b0);
    tick(); idle();
    chk("sb_addr", out_addr[31:0], 32'h203);
    chk("sb_byteen", out_byteen[3:0], 4'b1000);
    chk("sb_data", out_data[31:0], 32'hAB00_0000);
    chk("sb_rw", out_rw, 1);
    chk("sb_wid", out_wid, 2);
    tick();
    chk("sb_pend", pending_cnt, 2);

    // SH: lane0 at 0x201 (misaligned), lane1 at 0x202
    drive(LSU_SH, 4'h3, {64'd0, 32'h202, 32'h201}, 32'd0, {64'd0, 32'h5678, 32'h1234}, 2'd0, 1'b0);
    tick(); idle();
    chk("sh_byteen", out_byteen[7:0], 8'hC6);
    chk("sh_data", out_data[63:0], {32'h5678_0000, 32'h0012_3400});
    chk("sh_mis", out_misaligned, 4'b0001);
    tick();

    // LW with address wrap; misalignment masked by tmask
    drive(LSU_LW, 4'b0101, {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD}, 32'd4, 128'd0, 2'd0, 1'b0);
    tick(); idle();
    chk("wrap_addr0", out_addr[31:0], 32'h1);
    chk("wrap_addr2", out_addr[95:64], 32'h3);
    chk("wrap_mis", out_misaligned, 4'b0101);
    tick();

    // Reserved size
    drive(4'd3, 4'b1010, 128'd0, 32'd0, 128'd0, 2'd0, 1'b0);
    tick(); idle();
    chk("rsvd_byteen", out_byteen, 0);
    chk("rsvd_mis", out_misaligned, 4'b1010);
    tick();

    // Prefetch LHU behaves as a load
    drive(LSU_LHU, 4'hF, {4{32'h400}}, 32'd2, 128'd0, 2'd3, 1'b1);
    tick(); idle();
    chk("pf_rw", out_rw, 0);
    chk("pf_flag", out_is_prefetch, 1);
    chk("pf_op", out_op_type, 4'd5);
    chk("pf_byteen", out_byteen, 16'hCCCC);
    tick();
    chk("pf_pend", pending_cnt, 6);

    // Retire everything, then one extra retire at zero
    mem_rsp_done = 1'b1;
    repeat (7) tick();
    mem_rsp_done = 1'b0; #1;
    chk("drain_pend0", pending_cnt, 0);

    // Backpressure
    out_ready = 1'b0;
    drive(LSU_LW, 4'hF, {4{32'h1000}}, 32'd0, 128'd0, 2'd0, 1'b0);
    tick();
    drive(LSU_LW, 4'hF, {4{32'h2000}}, 32'd0, 128'd0, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_addr", out_addr[31:0], 32'h1000);
      tick();
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    drive(LSU_LW, 4'hF, {4{32'h3000}}, 32'd0, 128'd0, 2'd0, 1'b0);
    chk("b2b_addr_b", out_addr[31:0], 32'h2000);
    chk("b2b_in_ready", in_ready, 1);
    tick(); idle();
    chk("b2b_addr_c", out_addr[31:0], 32'h3000);
    chk("b2b_valid", out_valid, 1);
    tick();
    chk("b2b_pend", pending_cnt, 3);

    // Fence with 2 loads outstanding
    mem_rsp_done = 1'b1; tick(); mem_rsp_done = 1'b0; #1;
    chk("fence_pre_pend", pending_cnt, 2);
    drive_fence(2'd3);
    tick(); idle();
    chk("fence_in_ready", in_ready, 0);
    chk("fence_not_fwd", out_valid, 0);
    chk("fence_wait1", fence_done, 0);
    mem_rsp_done = 1'b1; tick(); mem_rsp_done = 1'b0; #1;
    chk("fence_wait2", fence_done, 0);
    mem_rsp_done = 1'b1; tick(); mem_rsp_done = 1'b0; #1;
    chk("fence_pend0", pending_cnt, 0);
    chk("fence_done", fence_done, 1);
    chk("fence_wid", fence_wid, 3);
    tick();
    chk("fence_pulse_end", fence_done, 0);
    chk("fence_idle_ready", in_ready, 1);

    // Fence while already empty
    drive_fence(2'd1);
    tick(); idle();
    chk("efence_done", fence_done, 1);
    chk("efence_wid", fence_wid, 1);
    chk("efence_in_ready", in_ready, 0);
    tick();
    chk("efence_end", fence_done, 0);

    // Fill to MAX_PENDING
    drive(LSU_LW, 4'hF, {4{32'h5000}}, 32'd0, 128'd0, 2'd0, 1'b0);
    repeat (15) tick();
    idle(); tick();
    chk("fill_pend15", pending_cnt, 15);
    out_ready = 1'b0;
    drive(LSU_LW, 4'hF, {4{32'h6000}}, 32'd0, 128'd0, 2'd0, 1'b0);
    tick();
    out_ready = 1'b1;
    drive(LSU_LW, 4'hF, {4{32'h7000}}, 32'd0, 128'd0, 2'd0, 1'b0);
    chk("fill_ready15", in_ready, 1);
    tick(); idle();
    chk("full_pend16", pending_cnt, 16);
    chk("full_in_ready", in_ready, 0);
    mem_rsp_done = 1'b1;
    drive(LSU_LW, 4'hF, {4{32'h8000}}, 32'd0, 128'd0, 2'd0, 1'b0);
    chk("full_rsp_ready", in_ready, 1);
    tick(); idle();
    mem_rsp_done = 1'b0; out_ready = 1'b0; #1;
    chk("full_pend_keep", pending_cnt, 16);
    chk("full_new_addr", out_addr[31:0], 32'h8000);

    // Fence into DRAIN with pending outstanding, then reset
    out_ready = 1'b1; mem_rsp_done = 1'b1;
    drive_fence(2'd2);
    tick(); idle();
    mem_rsp_done = 1'b0; #1;
    chk("mid_pend", pending_cnt, 16);
    chk("mid_drain_ready", in_ready, 0);
    reset = 1'b1; #1;
    chk("mid_rst_fdone", fence_done, 0);
    tick();
    reset = 1'b0; #1;
    chk("post_rst_pend", pending_cnt, 0);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_fdone", fence_done, 0);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_addr", out_addr, 0);
    chk("post_rst_fwid", fence_wid, 0);
    tick();
    chk("post_rst_fdone2", fence_done, 0);

    // Reset with a request held in the output register
    out_ready = 1'b0;
    drive(LSU_SW, 4'hF, {4{32'h9000}}, 32'd0, {4{32'h1111_2222}}, 2'd1, 1'b0);
    tick(); idle();
    chk("hold_valid", out_valid, 1);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_data", out_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
